// File: rtl/id_ex_stage.sv
// RV32I decode / ID-EX register feeding alu32, with valid/ready handshakes and flush.
// Define IDEX_SKID_EN to add a skid entry and register in_ready. Without it, in_ready is combinational.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_select,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] target
);

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [3:0]      sel;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] target;
  } bundle_t;

  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, jalr_sum;
  bundle_t         dec;
  bundle_t         main_q, main_d;
  logic            main_vld_q, main_vld_d;
  logic            accept;

  assign f3       = instr[14:12];
  assign imm_i    = XLEN'($signed(instr[31:20]));
  assign imm_s    = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u    = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_j    = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign shamt    = XLEN'(instr[24:20]);
  assign jalr_sum = rs1_data + imm_i;

  // Shift immediates carry funct7 in their upper bits, so only the shamt field is the operand.
  always_comb begin
    dec        = '0;
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    case (instr[6:0])
      7'b0110011: begin
        dec.x = rs1_data; dec.y = rs2_data;
        dec.sel = {instr[30], f3}; dec.reg_write = 1'b1;
      end
      7'b0010011: begin
        dec.x = rs1_data;
        dec.y = (f3[1:0] == 2'b01) ? shamt : imm_i;
        dec.sel = {(f3 == 3'b101) ? instr[30] : 1'b0, f3};
        dec.reg_write = 1'b1;
      end
      7'b0110111: begin
        dec.y = imm_u; dec.sel = 4'b1111; dec.reg_write = 1'b1;
      end
      7'b0010111: begin
        dec.x = pc; dec.y = imm_u; dec.reg_write = 1'b1;
      end
      7'b1101111: begin
        dec.x = pc; dec.y = XLEN'(4); dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.target = pc + imm_j;
      end
      7'b1100111: begin
        dec.x = pc; dec.y = XLEN'(4); dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      7'b1100011: begin
        dec.x = rs1_data; dec.y = rs2_data; dec.branch = 1'b1;
        dec.target = pc + imm_b;
        dec.sel = f3[2] ? {3'b001, f3[1]} : 4'b1000;
      end
      7'b0000011: begin
        dec.x = rs1_data; dec.y = imm_i; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
      end
      7'b0100011: begin
        dec.x = rs1_data; dec.y = imm_s; dec.mem_write = 1'b1; dec.store_data = rs2_data;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign accept = in_valid && in_ready;

`ifdef IDEX_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skid_vld_q, skid_vld_d;
  logic    in_ready_q;

  assign in_ready = in_ready_q;

  // in_ready_q mirrors an empty skid entry, so an accept never coincides with a full skid.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
    end
  end
`else
  assign in_ready = !main_vld_q || out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
    end else if (accept) begin
      main_d     = dec;
      main_vld_d = 1'b1;
    end else if (out_ready) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end
`endif

  assign out_valid  = main_vld_q;
  assign alu_x      = main_q.x;
  assign alu_y      = main_q.y;
  assign alu_select = main_q.sel;
  assign rd         = main_q.rd;
  assign reg_write  = main_q.reg_write;
  assign mem_read   = main_q.mem_read;
  assign mem_write  = main_q.mem_write;
  assign branch     = main_q.branch;
  assign jump       = main_q.jump;
  assign illegal    = main_q.illegal;
  assign funct3     = main_q.funct3;
  assign store_data = main_q.store_data;
  assign target     = main_q.target;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage with directed decode, burst, flush and reset scenarios.
// Build with or without IDEX_SKID_EN; the combinational in_ready check applies only without it.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jp, ill;
    logic [2:0]  f3;
    logic [31:0] sd;
    logic [31:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] alu_x, alu_y, store_data, target;
  logic [3:0]  alu_select;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  int   total = 0;
  int   bad = 0;
  int   outCount = 0;
  bit   lastInFire = 0;
  bit   heldValid = 0;
  exp_t held;
  exp_t sbq[$];

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_x(alu_x), .alu_y(alu_y),
    .alu_select(alu_select), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal),
    .funct3(funct3), .store_data(store_data), .target(target)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // Reference decode written from the instruction-set rules, one mnemonic class per branch.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] iI, iS, iB, iU, iJ;
    logic [2:0]  f;
    e = '0;
    f = ins[14:12];
    e.rd = ins[11:7];
    e.f3 = f;
    iI = $signed(ins) >>> 20;
    iS = {iI[31:5], ins[11:7]};
    iB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iU = {ins[31:12], 12'h000};
    iJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h33: begin e.x = a; e.y = b; e.sel = {ins[30], f}; e.rw = 1; end
      7'h13: begin
        e.x = a;
        e.y = (f == 3'd1 || f == 3'd5) ? {27'd0, ins[24:20]} : iI;
        e.sel = (f == 3'd5) ? {ins[30], f} : {1'b0, f};
        e.rw = 1;
      end
      7'h37: begin e.y = iU; e.sel = 4'hF; e.rw = 1; end
      7'h17: begin e.x = p; e.y = iU; e.rw = 1; end
      7'h6F: begin e.x = p; e.y = 4; e.jp = 1; e.rw = 1; e.tgt = p + iJ; end
      7'h67: begin e.x = p; e.y = 4; e.jp = 1; e.rw = 1; e.tgt = (a + iI) & 32'hFFFF_FFFE; end
      7'h63: begin
        e.x = a; e.y = b; e.br = 1; e.tgt = p + iB;
        case (f)
          3'd4, 3'd5: e.sel = 4'b0010;
          3'd6, 3'd7: e.sel = 4'b0011;
          default:    e.sel = 4'b1000;
        endcase
      end
      7'h03: begin e.x = a; e.y = iI; e.mr = 1; e.rw = 1; end
      7'h23: begin e.x = a; e.y = iS; e.mw = 1; e.sd = b; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t r;
    r = '{x: alu_x, y: alu_y, sel: alu_select, rd: rd, rw: reg_write, mr: mem_read,
          mw: mem_write, br: branch, jp: jump, ill: illegal, f3: funct3,
          sd: store_data, tgt: target};
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
    logic [2:0]  bf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    w = $urandom();
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h63) w[14:12] = bf[$urandom_range(0, 5)];
    if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic new_input();
    instr = rand_instr();
    pc = $urandom();
    rs1_data = $urandom();
    rs2_data = $urandom();
  endtask

  // One clock: settle, score handshakes against the model queue, then advance to the next negedge.
  task automatic tick();
    exp_t act, front;
    #1;
    act = actual();
`ifndef IDEX_SKID_EN
    total++;
    if (in_ready !== (!out_valid || out_ready)) begin
      bad++;
      $display("[TB] FAIL in_ready_comb: got %b want %b", in_ready, (!out_valid || out_ready));
    end
`endif
    if (heldValid) begin
      total++;
      if (out_valid !== 1'b1 || act !== held) begin
        bad++;
        $display("[TB] FAIL hold_stable: got v=%b %h want v=1 %h", out_valid, act, held);
      end
    end
    lastInFire = in_valid && in_ready;
    if (flush) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        outCount++;
        if (sbq.size() == 0) begin
          bad++;
          $display("[TB] FAIL spurious_out: got %h want no bundle", act);
        end else begin
          front = sbq.pop_front();
          if (act !== front) begin
            bad++;
            $display("[TB] FAIL bundle: got %h want %h", act, front);
          end
        end
      end
      if (lastInFire) sbq.push_back(model(instr, pc, rs1_data, rs2_data));
    end
    heldValid = out_valid && !out_ready && !flush;
    held = act;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    instr = i; pc = p; rs1_data = a; rs2_data = b;
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
  endtask

  task automatic drain(input int limit);
    in_valid = 0; flush = 0; out_ready = 1;
    for (int k = 0; k < limit && (sbq.size() != 0 || out_valid); k++) tick();
    total++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain: got pending=%0d v=%b want 0 0", sbq.size(), out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || actual() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%b rdy=%b %h want 0 1 0", out_valid, in_ready, actual());
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    send(32'h002081B3, 32'h0, 32'd10, 32'd20);
    total++;
    if (out_valid !== 1 || alu_x !== 32'd10 || alu_y !== 32'd20 || alu_select !== 4'b0000 ||
        rd !== 5'd3 || reg_write !== 1) begin
      bad++;
      $display("[TB] FAIL add: got v=%b x=%0d y=%0d sel=%b rd=%0d rw=%b want 1 10 20 0000 3 1",
               out_valid, alu_x, alu_y, alu_select, rd, reg_write);
    end
    drain(4);
    send(32'h40125213, 32'h0, 32'hFFFF_FFF0, 32'h0);
    total++;
    if (alu_select !== 4'b1101 || alu_y !== 32'd1 || alu_x !== 32'hFFFF_FFF0) begin
      bad++;
      $display("[TB] FAIL srai: got sel=%b y=%h x=%h want 1101 1 fffffff0", alu_select, alu_y, alu_x);
    end
    drain(4);
    send(32'h123452B7, 32'h40, 32'h5, 32'h6);
    total++;
    if (alu_select !== 4'b1111 || alu_y !== 32'h1234_5000 || alu_x !== 32'h0 || rd !== 5'd5) begin
      bad++;
      $display("[TB] FAIL lui: got sel=%b y=%h x=%h rd=%0d want 1111 12345000 0 5", alu_select, alu_y, alu_x, rd);
    end
    drain(4);
    send(32'hFE20ECE3, 32'h100, 32'd1, 32'd2);
    total++;
    if (alu_select !== 4'b0011 || branch !== 1 || target !== 32'hF8 || reg_write !== 0) begin
      bad++;
      $display("[TB] FAIL bltu: got sel=%b br=%b tgt=%h rw=%b want 0011 1 f8 0", alu_select, branch, target, reg_write);
    end
    drain(4);
    send(32'h00000013, 32'h0, 32'h0, 32'h0);
    total++;
    if (reg_write !== 0 || illegal !== 0 || out_valid !== 1) begin
      bad++;
      $display("[TB] FAIL addi_x0: got rw=%b ill=%b v=%b want 0 0 1", reg_write, illegal, out_valid);
    end
    drain(4);
    send(32'h0000007F, 32'h200, 32'hAAAA, 32'hBBBB);
    total++;
    if (illegal !== 1 || alu_select !== 4'b0000 || alu_x !== 0 || alu_y !== 0 ||
        reg_write !== 0 || mem_read !== 0 || mem_write !== 0 || branch !== 0 || jump !== 0) begin
      bad++;
      $display("[TB] FAIL illegal_op: got ill=%b sel=%b x=%h y=%h rw=%b want 1 0000 0 0 0",
               illegal, alu_select, alu_x, alu_y, reg_write);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int start = outCount;
    new_input();
    in_valid = 1;
    for (int cyc = 0; cyc < 40 && sent < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      tick();
      if (lastInFire) begin
        sent++;
        if (sent < 4) new_input();
        else in_valid = 0;
      end
    end
    in_valid = 0;
    drain(20);
    total++;
    if (outCount - start != 4) begin
      bad++;
      $display("[TB] FAIL burst_count: got %0d want 4", outCount - start);
    end
  endtask

  task automatic test_flush();
    int start;
    send(32'h002081B3, 32'h10, 32'd1, 32'd2);
    start = outCount;
    new_input();
    in_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_valid: got %b want 0", out_valid);
    end
    out_ready = 1;
    repeat (4) tick();
    total++;
    if (outCount != start || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_leak: got outs=%0d v=%b want 0 0", outCount - start, out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      new_input();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    drain(20);
  endtask

  task automatic test_reset_midburst();
    out_ready = 1;
    in_valid = 1;
    new_input();
    tick();
    new_input();
    tick();
    #2;
    rst_n = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || actual() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got v=%b rdy=%b %h want 0 1 0", out_valid, in_ready, actual());
    end
    sbq.delete();
    heldValid = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    out_ready = 1;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_partial: got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_random();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
